// File: rtl/mips_regfile_mp_pkg.sv
// Shared constants and the byte-merge helper for the multi-port MIPS register file.
// byte_merge works at a fixed maximum width; callers widen their operands and truncate the result.
package mips_rf_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int MAX_DATA_W = 256;
  localparam int MAX_BE_W   = MAX_DATA_W / 8;
  localparam int REG_ZERO   = 0;

  function automatic logic [MAX_DATA_W-1:0] byte_merge(
    input logic [MAX_DATA_W-1:0] old_val,
    input logic [MAX_DATA_W-1:0] new_val,
    input logic [MAX_BE_W-1:0]   be
  );
    logic [MAX_DATA_W-1:0] res;
    res = old_val;
    for (int k = 0; k < MAX_BE_W; k++) begin
      if (be[k]) res[8*k +: 8] = new_val[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mips_regfile_mp_if.sv
// Decode/writeback side bus of the register file: read ports, write port and scoreboard set.
interface mips_regfile_mp_if import mips_rf_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = 2
) ();

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     we;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic [DATA_W/8-1:0]      wr_be;
  logic                     sb_set;
  logic [ADDR_W-1:0]        sb_addr;

  modport master (
    output rd_addr, we, wr_addr, wr_data, wr_be, sb_set, sb_addr,
    input  rd_data, rd_busy
  );

  modport slave (
    input  rd_addr, we, wr_addr, wr_data, wr_be, sb_set, sb_addr,
    output rd_data, rd_busy
  );

endinterface

// File: rtl/mips_regfile_mp_read_port.sv
// One read port: register mux, write-first bypass, busy lookup and optional output register.
module mips_rf_read_port import mips_rf_pkg::*; #(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int READ_LAT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     regs [2**ADDR_W],
  input  logic [2**ADDR_W-1:0]  busy,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_be,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_busy
);

  logic              hit;
  logic [DATA_W-1:0] data_c;
  logic [DATA_W-1:0] data_q;
  logic              busy_c;
  logic              busy_q;

  // A same-cycle writeback both supplies the data and resolves the hazard.
  always_comb begin
    hit    = we && (wr_addr == rd_addr);
    data_c = regs[rd_addr];
    busy_c = busy[rd_addr] & ~hit;
    if (hit)
      data_c = DATA_W'(byte_merge(MAX_DATA_W'(regs[rd_addr]), MAX_DATA_W'(wr_data),
                                  MAX_BE_W'(wr_be)));
    if (rd_addr == ADDR_W'(REG_ZERO)) begin
      data_c = '0;
      busy_c = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      busy_q <= 1'b0;
    end else begin
      data_q <= data_c;
      busy_q <= busy_c;
    end
  end

  assign rd_data = (READ_LAT == 1) ? data_q : data_c;
  assign rd_busy = (READ_LAT == 1) ? busy_q : busy_c;

endmodule

// File: rtl/mips_regfile_mp.sv
// Multi-port MIPS register file: R0 hardwired to zero, byte-enabled write port,
// NUM_RD bypassed read ports and a per-register busy scoreboard.
module mips_regfile_mp import mips_rf_pkg::*; #(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int READ_LAT = 0
) (
  input logic               clk,
  input logic               rst,
  mips_regfile_mp_if.slave  bus
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic [DATA_W-1:0] wr_merged;

  assign wr_merged = DATA_W'(byte_merge(MAX_DATA_W'(regs[bus.wr_addr]), MAX_DATA_W'(bus.wr_data),
                                        MAX_BE_W'(bus.wr_be)));

  // Writeback clears first, then a new producer re-marks so set wins on a collision.
  always_comb begin
    busy_nxt = busy;
    if (bus.we) busy_nxt[bus.wr_addr] = 1'b0;
    if (bus.sb_set && (bus.sb_addr != ADDR_W'(REG_ZERO))) busy_nxt[bus.sb_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      if (bus.we && (bus.wr_addr != ADDR_W'(REG_ZERO))) regs[bus.wr_addr] <= wr_merged;
      busy <= busy_nxt;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    mips_rf_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .READ_LAT (READ_LAT)
    ) u_port (
      .clk     (clk),
      .rst     (rst),
      .regs    (regs),
      .busy    (busy),
      .we      (bus.we),
      .wr_addr (bus.wr_addr),
      .wr_data (bus.wr_data),
      .wr_be   (bus.wr_be),
      .rd_addr (bus.rd_addr[i*ADDR_W +: ADDR_W]),
      .rd_data (bus.rd_data[i*DATA_W +: DATA_W]),
      .rd_busy (bus.rd_busy[i])
    );
  end

endmodule
